// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: coprocessor-0 exception/interrupt controller for the P7 core.
// Holds SR(12), Cause(13), EPC(14) and PRId(15). It raises Req for an enabled
// interrupt or a synchronous exception, and serves mfc0/mtc0/eret from M stage.
// Optional feature macro: CP0_BADVADDR_EN adds the BadAddr input and the
// read-only BadVAddr register (CP0 register 8).
module cp0_irq_ctrl #(
  parameter logic [31:0] PRID    = 32'h0000_0714,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] BadAddr,
`endif
  output logic [31:0] Dout,
  output logic        Req,
  output logic [31:0] EPCOut
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // The handler address is applied by the fetch logic; it must be word aligned.
  if (HANDLER[1:0] != 2'b00) begin : g_bad_handler
    $error("cp0_irq_ctrl: HANDLER must be word aligned");
  end

  // SR fields
  logic [5:0]  sr_im_q,  sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q,  sr_ie_d;
  // Cause fields
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  // EPC keeps only the word address; the two low bits always read 0.
  logic [29:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;
`endif

  logic        int_req;
  logic        exc_req;
  logic        take_req;
  logic [4:0]  rec_code;
  logic [29:0] victim_word;
  logic        unused_pc_low;

  // Request generation; reset masks Req even if ExcCode is already non-zero.
  always_comb begin
    int_req  = sr_ie_q & ~sr_exl_q & (|(HWInt & sr_im_q));
    exc_req  = ~sr_exl_q & (ExcCode != 5'd0);
    take_req = ~reset & (int_req | exc_req);
    rec_code = int_req ? 5'd0 : ExcCode;
    // A delay-slot victim resumes at the branch, one word earlier (mod 2^32).
    victim_word = BD ? (PC[31:2] - 30'd1) : PC[31:2];
  end

  // The PC low bits never reach EPC; word alignment is implied.
  assign unused_pc_low = ^PC[1:0];

  assign Req    = take_req;
  assign EPCOut = {epc_q, 2'b00};

  // Combinational register read, no bypass of a same-cycle mtc0.
  always_comb begin
    Dout = 32'd0;
    case (A1)
      REG_SR:    Dout = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
      REG_CAUSE: Dout = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'b00};
      REG_EPC:   Dout = {epc_q, 2'b00};
      REG_PRID:  Dout = PRID;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: Dout = badvaddr_q;
`endif
      default:   Dout = 32'd0;
    endcase
  end

  // Next-state: a taken request overrides mtc0 and eret; IP always samples HWInt.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
`ifdef CP0_BADVADDR_EN
    badvaddr_d  = badvaddr_q;
`endif
    cause_ip_d  = HWInt;

    if (take_req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = BD;
      cause_exc_d = rec_code;
      epc_d       = victim_word;
`ifdef CP0_BADVADDR_EN
      if ((rec_code == EXC_ADEL) || (rec_code == EXC_ADES)) begin
        badvaddr_d = BadAddr;
      end
`endif
    end else begin
      if (WE && (A2 == REG_SR)) begin
        sr_im_d  = Din[15:10];
        sr_exl_d = Din[1];
        sr_ie_d  = Din[0];
      end
      if (WE && (A2 == REG_EPC)) begin
        epc_d = Din[31:2];
      end
      // eret wins over a same-cycle mtc0 for the EXL bit only.
      if (EXLClr) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 30'd0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q  <= 32'd0;
`endif
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
`ifdef CP0_BADVADDR_EN
      badvaddr_q  <= badvaddr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Bench for cp0_irq_ctrl: directed steps from the test plan followed by a
// randomized run, all compared against a register-level behavioural model.
module tb_cp0_irq_ctrl;

  localparam logic [31:0] PRID_V = 32'h0000_0714;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode;
  logic [31:0] Din, PC;
  logic        WE, BD, EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] Dout, EPCOut;
  logic        Req;
`ifdef CP0_BADVADDR_EN
  logic [31:0] BadAddr;
`endif

  always #5 clk = ~clk;

  cp0_irq_ctrl dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
    .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
`ifdef CP0_BADVADDR_EN
    .BadAddr(BadAddr),
`endif
    .Dout(Dout), .Req(Req), .EPCOut(EPCOut)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: architectural register fields, EPC kept as a full word.
  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic [31:0] m_badv;

  task automatic model_reset();
    m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = '0;
    m_epc = '0; m_badv = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return (32'(m_im) << 10) + (32'(m_exl) << 1) + 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) + (32'(m_ip) << 10) + (32'(m_code) << 2);
      5'd14: return m_epc;
      5'd15: return PRID_V;
`ifdef CP0_BADVADDR_EN
      5'd8:  return m_badv;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input bit req, input bit intr);
    logic [4:0] code;
    code = intr ? 5'd0 : ExcCode;
    if (req) begin
      m_exl  = 1;
      m_bd   = BD;
      m_code = code;
      m_epc  = (BD ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;
`ifdef CP0_BADVADDR_EN
      if (code == 5'd4 || code == 5'd5) m_badv = BadAddr;
`endif
    end else begin
      if (WE && A2 == 5'd12) begin
        m_im = Din[15:10]; m_exl = Din[1]; m_ie = Din[0];
      end
      if (WE && A2 == 5'd14) m_epc = Din & 32'hFFFF_FFFC;
      if (EXLClr) m_exl = 0;
    end
    m_ip = HWInt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model mid-cycle, then clock once and update the model.
  task automatic tick();
    bit intr, exc, req;
    #1;
    intr = m_ie && !m_exl && ((HWInt & m_im) != 6'd0);
    exc  = !m_exl && (ExcCode != 5'd0);
    req  = intr || exc;
    check("model_req", {31'd0, Req}, {31'd0, req});
    check("model_dout", Dout, m_read(A1));
    check("model_epcout", EPCOut, m_epc);
    @(posedge clk);
    model_edge(req, intr);
    @(negedge clk);
  endtask

  task automatic expect_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    check(tag, Dout, exp);
    tick();
  endtask

  task automatic expect_req(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, Req}, {31'd0, exp});
  endtask

  task automatic clear_exl();
    HWInt = '0; ExcCode = '0; WE = 0; BD = 0; EXLClr = 1;
    tick();
    EXLClr = 0;
  endtask

  initial begin
    reset = 1; A1 = '0; A2 = '0; Din = '0; WE = 0; PC = '0; BD = 0;
    ExcCode = '0; HWInt = '0; EXLClr = 0;
`ifdef CP0_BADVADDR_EN
    BadAddr = '0;
`endif
    model_reset();

    // Outputs while reset is held
    #1; A1 = 5'd15; ExcCode = 5'd10;
    #1; check("rst_prid", Dout, PRID_V);
    check("rst_req_masked", {31'd0, Req}, 32'd0);
    A1 = 5'd14;
    #1; check("rst_epc", Dout, 32'd0);
    check("rst_epcout", EPCOut, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 0; ExcCode = '0;

    // Register reset values
    expect_reg("sr_reset", 5'd12, 32'd0);
    expect_reg("cause_reset", 5'd13, 32'd0);
    expect_reg("epc_reset", 5'd14, 32'd0);
    expect_reg("prid", 5'd15, PRID_V);
    expect_req("req_reset", 1'b0);
    tick();

    // Timer interrupt
    WE = 1; A2 = 5'd12; Din = 32'h0000_0401;
    tick();
    WE = 0; HWInt = 6'b000001; PC = 32'h0000_3010; BD = 0;
    expect_req("timer_req", 1'b1);
    tick();
    expect_reg("timer_epc", 5'd14, 32'h0000_3010);
    expect_reg("timer_sr", 5'd12, 32'h0000_0403);
    expect_reg("timer_cause", 5'd13, 32'h0000_0400);
    expect_req("timer_req_masked", 1'b0);
    tick();

    // eret with interrupt still pending; then Req with EXLClr keeps EXL
    EXLClr = 1;
    expect_req("eret_req_cycle", 1'b0);
    tick();
    A1 = 5'd12; EXLClr = 1; PC = 32'h0000_3040;
    expect_req("eret_retake", 1'b1);
    check("eret_exl_clear", Dout, 32'h0000_0401);
    tick();
    EXLClr = 0;
    expect_reg("req_beats_eret", 5'd12, 32'h0000_0403);
    expect_reg("retake_epc", 5'd14, 32'h0000_3040);

    // Exception in a delay slot
    clear_exl();
    ExcCode = 5'd10; BD = 1; PC = 32'h0000_3024;
    expect_req("ri_req", 1'b1);
    tick();
    ExcCode = '0; BD = 0;
    expect_reg("ri_epc", 5'd14, 32'h0000_3020);
    expect_reg("ri_cause", 5'd13, 32'h8000_0028);

    // Interrupt and overflow together
    clear_exl();
    HWInt = 6'b000001; ExcCode = 5'd12; PC = 32'h0000_3050;
    expect_req("int_ov_req", 1'b1);
    tick();
    ExcCode = '0;
    expect_reg("int_ov_cause", 5'd13, 32'h0000_0400);
    expect_reg("int_ov_epc", 5'd14, 32'h0000_3050);

    // mtc0 dropped when Req is taken
    clear_exl();
    ExcCode = 5'd8; WE = 1; A2 = 5'd14; Din = 32'hDEAD_BEE0; PC = 32'h0000_5000;
    tick();
    WE = 0; ExcCode = '0;
    expect_reg("we_dropped", 5'd14, 32'h0000_5000);

    // PC-4 wraps
    clear_exl();
    PC = 32'h0; BD = 1; ExcCode = 5'd10;
    tick();
    BD = 0; ExcCode = '0;
    expect_reg("epc_wrap", 5'd14, 32'hFFFF_FFFC);

    // mtc0 SR with EXLClr: EXL cleared, IM/IE from Din
    WE = 1; A2 = 5'd12; Din = 32'h0000_0803; EXLClr = 1;
    tick();
    WE = 0; EXLClr = 0;
    expect_reg("sr_we_eret", 5'd12, 32'h0000_0801);

    // Writes to Cause and PRId ignored
    WE = 1; A2 = 5'd13; Din = 32'hFFFF_FFFF;
    tick();
    A2 = 5'd15;
    tick();
    WE = 0;
    expect_reg("cause_ro", 5'd13, 32'h8000_0028);
    expect_reg("prid_ro", 5'd15, PRID_V);

    // EPC write masks low bits
    WE = 1; A2 = 5'd14; Din = 32'h1234_5677;
    tick();
    WE = 0;
    #1; check("epcout_write", EPCOut, 32'h1234_5674);
    expect_reg("epc_write", 5'd14, 32'h1234_5674);

`ifdef CP0_BADVADDR_EN
    ExcCode = 5'd4; BadAddr = 32'h0000_7F01; PC = 32'h0000_6000;
    tick();
    ExcCode = '0;
    expect_reg("badvaddr", 5'd8, 32'h0000_7F01);
    WE = 1; A2 = 5'd8; Din = 32'h0;
    tick();
    WE = 0;
    expect_reg("badvaddr_ro", 5'd8, 32'h0000_7F01);
`else
    WE = 1; A2 = 5'd8; Din = 32'hFFFF_FFFF;
    tick();
    WE = 0;
    expect_reg("reg8_zero", 5'd8, 32'h0);
`endif
    clear_exl();

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      int pick;
      HWInt   = 6'($urandom);
      ExcCode = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      BD      = 1'($urandom);
      PC      = $urandom;
      EXLClr  = ($urandom_range(0, 2) == 0);
      WE      = ($urandom_range(0, 3) == 0);
      Din     = $urandom;
`ifdef CP0_BADVADDR_EN
      BadAddr = $urandom;
`endif
      pick = $urandom_range(0, 5);
      case (pick)
        0: A2 = 5'd8;
        1: A2 = 5'd12;
        2: A2 = 5'd13;
        3: A2 = 5'd14;
        4: A2 = 5'd15;
        default: A2 = 5'($urandom);
      endcase
      pick = $urandom_range(0, 5);
      case (pick)
        0: A1 = 5'd8;
        1: A1 = 5'd12;
        2: A1 = 5'd13;
        3: A1 = 5'd14;
        4: A1 = 5'd15;
        default: A1 = 5'($urandom);
      endcase
      tick();
    end

    // Reset asserted mid-operation
    WE = 0; EXLClr = 0; ExcCode = 5'd10; A1 = 5'd14;
    reset = 1;
    #1;
    check("midrst_req", {31'd0, Req}, 32'd0);
    check("midrst_epcout", EPCOut, 32'd0);
    check("midrst_epc", Dout, 32'd0);
    A1 = 5'd15;
    #1; check("midrst_prid", Dout, PRID_V);
    model_reset();
    @(negedge clk);
    reset = 0; ExcCode = '0; HWInt = '0;
    expect_reg("midrst_sr", 5'd12, 32'd0);
    expect_req("midrst_req_after", 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
